// File: rtl/seg7_pkg.sv
// ============================================================================
// seg7_pkg : segment pattern type, constants and code->segment decode function
// Revision : 1.0
// ============================================================================
`default_nettype none

package seg7_pkg;

  typedef logic [6:0] seg_t;  // {a,b,c,d,e,f,g}, active low

  localparam seg_t SEG_BLANK = 7'h7F;
  localparam seg_t SEG_DASH  = 7'b1111110;

  localparam seg_t SEG_0 = 7'b0000001;
  localparam seg_t SEG_1 = 7'b1001111;
  localparam seg_t SEG_2 = 7'b0010010;
  localparam seg_t SEG_3 = 7'b0000110;
  localparam seg_t SEG_4 = 7'b1001100;
  localparam seg_t SEG_5 = 7'b0100100;
  localparam seg_t SEG_6 = 7'b0100000;
  localparam seg_t SEG_7 = 7'b0001111;
  localparam seg_t SEG_8 = 7'b0000000;
  localparam seg_t SEG_9 = 7'b0000100;
  localparam seg_t SEG_A = 7'b0001000;
  localparam seg_t SEG_B = 7'b1100000;
  localparam seg_t SEG_C = 7'b0110001;
  localparam seg_t SEG_D = 7'b1000010;
  localparam seg_t SEG_E = 7'b0110000;
  localparam seg_t SEG_F = 7'b0111000;

  // Packed table: entry i is the pattern for code i.
  localparam logic [15:0][6:0] SEG_HEX_TABLE = {
    SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
    SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0
  };

  function automatic seg_t seg7_decode(input logic [3:0] code, input logic hex_mode);
    seg_t seg;
    if ((code > 4'd9) && !hex_mode) seg = SEG_DASH;
    else                            seg = SEG_HEX_TABLE[code];
    return seg;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_scan_ctrl_decoder.sv
// ============================================================================
// seg7_decoder : combinational 4-bit code to active-low 7-segment pattern
// Revision     : 1.0
// ============================================================================
`default_nettype none

module seg7_decoder
  import seg7_pkg::*;
#(
  parameter int HEX_MODE = 0
) (
  input  logic [3:0] i_code,
  output seg_t       o_seg
);

  assign o_seg = seg7_decode(i_code, (HEX_MODE != 0));

endmodule

`default_nettype wire

// File: rtl/seg7_scan_ctrl.sv
// ============================================================================
// seg7_scan_ctrl : multiplexed common-anode 7-segment scanner with PWM
//                  brightness, per-digit enable/dp and optional blink
//                  (blink enabled by defining SEG7_BLINK_EN)
// Revision       : 1.0
// ============================================================================
`default_nettype none

module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 100000,
  parameter int BRIGHT_W    = 4,
  parameter int HEX_MODE    = 0,
  parameter int BLINK_DIV   = 50000000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] i_digits_in,
  input  logic [NUM_DIGITS-1:0]   i_dp_in,
  input  logic [NUM_DIGITS-1:0]   i_digit_en,
  input  logic [BRIGHT_W-1:0]     i_brightness,
`ifdef SEG7_BLINK_EN
  input  logic [NUM_DIGITS-1:0]   i_blink_mask,
`endif
  output logic [NUM_DIGITS-1:0]   o_anodes_n,
  output seg_t                    o_cathodes_n,
  output logic                    o_dp_n
);

  localparam int PRE_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);

  logic [PRE_W-1:0]        r_presc;
  logic [IDX_W-1:0]        r_scan;
  logic [BRIGHT_W-1:0]     r_pwm;
  logic [4*NUM_DIGITS-1:0] r_digits;
  logic [NUM_DIGITS-1:0]   r_dp;
  logic [NUM_DIGITS-1:0]   r_en;

  logic                    w_slot_tick;
  logic                    w_frame_wrap;
  logic [PRE_W-1:0]        w_presc_nxt;
  logic [IDX_W-1:0]        w_scan_nxt;
  logic [BRIGHT_W-1:0]     w_pwm_nxt;
  logic [4*NUM_DIGITS-1:0] w_digits_nxt;
  logic [NUM_DIGITS-1:0]   w_dp_nxt;
  logic [NUM_DIGITS-1:0]   w_en_nxt;
  logic                    w_lit;
  logic                    w_blinked;
  logic                    w_show;
  logic [3:0]              w_code;
  seg_t                    w_seg;

  assign w_slot_tick  = (r_presc == PRE_W'(REFRESH_DIV - 1));
  assign w_frame_wrap = w_slot_tick && (r_scan == IDX_W'(NUM_DIGITS - 1));
  assign w_presc_nxt  = w_slot_tick ? '0 : r_presc + 1'b1;
  assign w_scan_nxt   = w_frame_wrap ? '0 : (w_slot_tick ? r_scan + 1'b1 : r_scan);
  assign w_pwm_nxt    = r_pwm + 1'b1;

  // Snapshot is taken at frame start so a whole frame shows one coherent value.
  assign w_digits_nxt = w_frame_wrap ? i_digits_in : r_digits;
  assign w_dp_nxt     = w_frame_wrap ? i_dp_in     : r_dp;
  assign w_en_nxt     = w_frame_wrap ? i_digit_en  : r_en;

  assign w_lit = (&i_brightness) || (w_pwm_nxt < i_brightness);

`ifdef SEG7_BLINK_EN
  localparam int BLK_W = $clog2(BLINK_DIV);

  logic [BLK_W-1:0] r_blink_cnt;
  logic             r_blink_phase;
  logic             w_blink_hit;
  logic             w_blink_phase_nxt;

  assign w_blink_hit       = (r_blink_cnt == BLK_W'(BLINK_DIV - 1));
  assign w_blink_phase_nxt = r_blink_phase ^ w_blink_hit;
  assign w_blinked         = w_blink_phase_nxt && i_blink_mask[w_scan_nxt];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else begin
      r_blink_cnt   <= w_blink_hit ? '0 : r_blink_cnt + 1'b1;
      r_blink_phase <= w_blink_phase_nxt;
    end
  end
`else
  logic w_unused_blink_div;
  assign w_unused_blink_div = ^32'(BLINK_DIV);
  assign w_blinked          = 1'b0;
`endif

  assign w_show = w_lit && w_en_nxt[w_scan_nxt] && !w_blinked;
  assign w_code = w_digits_nxt[{w_scan_nxt, 2'b00} +: 4];

  seg7_decoder #(
    .HEX_MODE (HEX_MODE)
  ) u_decoder (
    .i_code (w_code),
    .o_seg  (w_seg)
  );

  // Outputs are computed from next-state so they change on the same edge as scan_idx.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc      <= '0;
      r_scan       <= '0;
      r_pwm        <= '0;
      r_digits     <= '0;
      r_dp         <= '0;
      r_en         <= '0;
      o_anodes_n   <= '1;
      o_cathodes_n <= SEG_BLANK;
      o_dp_n       <= 1'b1;
    end else begin
      r_presc      <= w_presc_nxt;
      r_scan       <= w_scan_nxt;
      r_pwm        <= w_pwm_nxt;
      r_digits     <= w_digits_nxt;
      r_dp         <= w_dp_nxt;
      r_en         <= w_en_nxt;
      o_anodes_n   <= w_show ? ~(NUM_DIGITS'(1) << w_scan_nxt) : '1;
      o_cathodes_n <= w_show ? w_seg : SEG_BLANK;
      o_dp_n       <= w_show ? ~w_dp_nxt[w_scan_nxt] : 1'b1;
    end
  end

endmodule

`default_nettype wire
